alu_sequencer: RTL
==================

# alu_sequencer

Instruction-driven controller for the 4-bit bus/accumulator/ALU datapath. Accepts 8-bit instruction words over a valid/ready handshake, drives the datapath's bus-driver enables, accumulator enable, ALU selector and input-bus data, and captures the ALU carry/zero flags. It supports conditional skip of the next instruction and a handshaked result output. It sits between an instruction source (testbench, ROM walker or host) and the datapath interconnect.

## Interface
- DATA_W, 4, datapath width; fixed at 4, not to be overridden.
- CNT_W, 16, width of the executed-instruction counter (only with ALU_SEQ_COUNT_EN).

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction word present
- in_ready  out  1  sequencer can accept a word
- in_instr  in  8  [7:4] opcode, [3:0] immediate
- bus_data  out  4  immediate driven to datapath INBUS
- en_bus_in  out  1  input bus driver enable
- en_bus_out  out  1  output bus driver enable
- en_accu  out  1  accumulator load enable
- alu_sel  out  3  ALU selector (000 A, 001 A-B, 010 B, 011 A+B, 100 NAND)
- cz_in  in  2  datapath flags {C, Z}, combinational from ALU
- flags  out  2  registered {C, Z}
- out_valid  out  1  accumulator value is on the output bus
- out_ready  in  1  consumer takes output
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  CNT_W  executed instructions (only with ALU_SEQ_COUNT_EN)

## Operation
- Opcodes: 0 NOP, 1 LIT (ACC=imm), 2 ADD, 3 SUB, 4 NAND, 5 CMP (SUB, no ACC write), 6 OUT, 7 SKZ (skip next if Z), 8 SKC (skip next if C), 9–F illegal.
- FSM states: IDLE, EXEC, OUTW.
- IDLE: in_ready=1, all enables 0, alu_sel=000. On in_valid&in_ready, latch instr; go to OUTW for OUT (unless skipping), else EXEC.
- EXEC (exactly one cycle): bus_data=imm. LIT/ADD/SUB/NAND: en_bus_in=1, en_accu=1, alu_sel per op. CMP: en_bus_in=1, en_accu=0, alu_sel=001. At the end-of-cycle edge, flags are captured: Z=cz_in[0]; C=cz_in[1] for ADD/SUB/CMP, C=0 for LIT/NAND. NOP/SKZ/SKC/illegal: no enables, flags unchanged. Then go to IDLE.
- SKZ/SKC: set skip_pending if the named registered flag is 1; otherwise no effect.
- skip_pending: the next accepted word is consumed with no datapath effect, no flag change and no count; skip_pending then clears. A skipped OUT does not enter OUTW.
- OUTW: alu_sel=000, en_bus_out=1, out_valid=1, in_ready=0. Hold until out_ready=1 at an edge, then go to IDLE.
- Illegal opcode: illegal set (sticky until reset); executes as NOP.
- Arithmetic is the datapath's 4-bit modulo arithmetic; SUB borrow appears as C=1.

## Timing
- Reset (any state, including mid-EXEC/OUTW): state=IDLE, in_ready=1, all enables 0, alu_sel=000, bus_data=0, flags=00, out_valid=0, illegal=0, skip_pending=0, instr_count=0. Accumulator reset belongs to the datapath.
- Accept at edge N → EXEC during cycle N+1 → ACC/flags valid after edge N+2. Throughput is 1 instruction per 2 cycles.
- OUT: out_valid rises the cycle after accept. Minimum 1 cycle in OUTW; in_ready returns the cycle after the out_ready handshake.
- in_ready is never high in EXEC or OUTW. in_instr is ignored when in_ready=0.
- All outputs are registered or decoded from registered state only; no combinational path from in_* or out_ready to outputs.

## Configuration
- ALU_SEQ_COUNT_EN defined: instr_count port and register exist. The counter increments by 1 per non-skipped instruction, including NOP and illegal, at EXEC exit or OUTW exit. It wraps at 2^CNT_W and clears on reset.
- Undefined: no port, no register; behaviour otherwise identical.

## Structure
- Shared package/include: opcode constants, ALU selector codes, FSM state encodings, DATA_W.
- One sub-module, alu_seq_decode: combinational opcode → {en_bus_in, en_accu, alu_sel, writes_flags, c_valid, is_out, is_skip, illegal}.

## Test plan
- LIT 5, ADD 4 → ACC=9, flags=00. Then ADD 9 → ACC=2, flags C=1 Z=0.
- LIT 3, SUB 5 → ACC=14, C=1. LIT 3, CMP 3 → ACC stays 3, Z=1, en_accu never high.
- CMP giving Z=1, then SKZ, then OUT → OUT consumed, out_valid never asserts. Next OUT → out_valid=1 with ACC on bus.
- OUT with out_ready low 3 cycles → out_valid and en_bus_out held 3 cycles, in_ready=0. out_ready=1 → IDLE next cycle.
- Opcode 0xF → illegal=1 and stays set through later legal instructions; cleared only by reset.
- reset asserted during OUTW → next cycle IDLE, out_valid=0, flags=00. With ALU_SEQ_COUNT_EN, 5 executed + 1 skipped → instr_count=5.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer.
// Optional instruction counter is enabled with ALU_SEQ_COUNT_EN.
package alu_seq_pkg;

  localparam int DATA_W  = 4;
  localparam int INSTR_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LIT  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_NAND = 4'h4,
    OP_CMP  = 4'h5,
    OP_OUT  = 4'h6,
    OP_SKZ  = 4'h7,
    OP_SKC  = 4'h8
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_A    = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_B    = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_NAND = 3'b100
  } alu_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_OUTW = 2'd2
  } state_e;

  typedef struct packed {
    logic       en_bus_in;
    logic       en_accu;
    logic [2:0] alu_sel;
    logic       writes_flags;
    logic       c_valid;
    logic       is_out;
    logic       is_skip;
    logic       illegal;
  } dec_t;

  function automatic logic [3:0] op_of(input logic [INSTR_W-1:0] w);
    return w[7:4];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake and datapath-control bundle between sequencer and its environment.
// Optional instruction counter (ALU_SEQ_COUNT_EN) lives on the top module.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  bus_data;
  logic               en_bus_in;
  logic               en_bus_out;
  logic               en_accu;
  logic [2:0]         alu_sel;
  logic [1:0]         cz_in;
  logic [1:0]         flags;
  logic               out_valid;
  logic               out_ready;
  logic               illegal;

  modport master (
    input  in_valid, in_instr, cz_in, out_ready,
    output in_ready, bus_data, en_bus_in, en_bus_out,
    output en_accu, alu_sel, flags, out_valid, illegal
  );

  modport slave (
    output in_valid, in_instr, cz_in, out_ready,
    input  in_ready, bus_data, en_bus_in, en_bus_out,
    input  en_accu, alu_sel, flags, out_valid, illegal
  );

endinterface

// File: rtl/alu_seq_decode.sv
// Opcode decoder: maps a 4-bit opcode onto datapath controls.
// Optional instruction counter (ALU_SEQ_COUNT_EN) is handled in the top.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.alu_sel = ALU_A;
    unique case (1'b1)
      (op == OP_NOP): ;
      (op == OP_LIT): begin
        dec.en_bus_in    = 1'b1;
        dec.en_accu      = 1'b1;
        dec.alu_sel      = ALU_B;
        dec.writes_flags = 1'b1;
      end
      (op == OP_ADD): begin
        dec.en_bus_in    = 1'b1;
        dec.en_accu      = 1'b1;
        dec.alu_sel      = ALU_ADD;
        dec.writes_flags = 1'b1;
        dec.c_valid      = 1'b1;
      end
      (op == OP_SUB): begin
        dec.en_bus_in    = 1'b1;
        dec.en_accu      = 1'b1;
        dec.alu_sel      = ALU_SUB;
        dec.writes_flags = 1'b1;
        dec.c_valid      = 1'b1;
      end
      (op == OP_NAND): begin
        dec.en_bus_in    = 1'b1;
        dec.en_accu      = 1'b1;
        dec.alu_sel      = ALU_NAND;
        dec.writes_flags = 1'b1;
      end
      (op == OP_CMP): begin
        dec.en_bus_in    = 1'b1;
        dec.alu_sel      = ALU_SUB;
        dec.writes_flags = 1'b1;
        dec.c_valid      = 1'b1;
      end
      (op == OP_OUT): dec.is_out = 1'b1;
      (op == OP_SKZ),
      (op == OP_SKC): dec.is_skip = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 4-bit accumulator/ALU datapath.
// Define ALU_SEQ_COUNT_EN to add the executed-instruction counter.
module alu_sequencer
  import alu_seq_pkg::*;
`ifdef ALU_SEQ_COUNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  alu_seq_if.master        bus
`ifdef ALU_SEQ_COUNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  dec_t               dec_in, dec_q;
  logic [1:0]         flags_q;
  logic               skip_q;
  logic               illegal_q;
  logic               accept;
  logic               in_exec;
  logic               in_outw;
  logic               skip_hit;

  alu_seq_decode u_dec (
    .op  (op_of(bus.in_instr)),
    .dec (dec_in)
  );

  assign accept  = bus.in_valid && (state_q == S_IDLE);
  assign in_exec = (state_q == S_EXEC);
  assign in_outw = (state_q == S_OUTW);

  // SKZ tests Z (bit 0), SKC tests C (bit 1)
  assign skip_hit = (op_of(instr_q) == OP_SKZ) ? flags_q[0]
                                               : flags_q[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !skip_q)
          state_d = dec_in.is_out ? S_OUTW : S_EXEC;
      end
      S_EXEC: state_d = S_IDLE;
      S_OUTW: begin
        if (bus.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == S_IDLE);
    bus.en_bus_in  = in_exec && dec_q.en_bus_in;
    bus.en_accu    = in_exec && dec_q.en_accu;
    bus.alu_sel    = in_exec ? dec_q.alu_sel : ALU_A;
    bus.bus_data   = in_exec ? instr_q[3:0] : '0;
    bus.en_bus_out = in_outw;
    bus.out_valid  = in_outw;
    bus.flags      = flags_q;
    bus.illegal    = illegal_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      dec_q     <= '0;
      flags_q   <= 2'b00;
      skip_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (skip_q) begin
          skip_q <= 1'b0;
        end else begin
          instr_q <= bus.in_instr;
          dec_q   <= dec_in;
        end
      end
      if (in_exec) begin
        if (dec_q.writes_flags)
          flags_q <= {dec_q.c_valid & bus.cz_in[1], bus.cz_in[0]};
        if (dec_q.is_skip && skip_hit)
          skip_q <= 1'b1;
        if (dec_q.illegal)
          illegal_q <= 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (in_exec || (in_outw && bus.out_ready))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count = cnt_q;
`endif

endmodule
